pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the phase-clocked pipelined CPU.
- Replaces the fixed Execute/Writeback instruction-passing registers with a DEPTH-deep pipeline of destination tags.
- Drives operand-forwarding selects, load-use stalls and branch flushes.
- Sits between instruction decode (Control) and the register-file/ALU operand muxes. Pipeline advance is strobed once per instruction cycle by the phase-0 clock phase.

Parameters:
- REG_W, 5: register specifier width.
- DEPTH, 2: in-flight stages after decode that are tracked and forwardable; legal range 1..7.
- LOAD_LAT, 1: number of youngest stages whose load result is not yet available (load-use bubbles); legal range 0..DEPTH-1.
- ZERO_REG, 31: register index hardwired to zero (XZR). It is never a forwarding source.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  system clock
- Reset  in  1  reset, synchronous, active-low
- advance  in  1  one-cycle pipeline advance strobe (phase-0 edge)
- id_valid  in  1  decode-stage instruction present
- id_rs1  in  REG_W  decode source A specifier
- id_rs2  in  REG_W  decode source B specifier (after R2LOC mux)
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_W  decode destination specifier
- id_we  in  1  instruction writes register file
- id_is_load  in  1  instruction is a load (LDUR)
- branch_taken  in  1  oldest stage (DEPTH-1) resolved a taken branch
- fwd_sel_a  out  SEL_W  operand A source: 0 = register file, k = stage k-1; SEL_W = clog2(DEPTH+1)
- fwd_sel_b  out  SEL_W  operand B source, same encoding as fwd_sel_a
- stall  out  1  load-use hazard; hold decode
- id_ready  out  1  equals ~stall; front end must hold its instruction at an advance when id_ready is low
- flush  out  1  taken branch in the oldest stage
- stage_valid  out  DEPTH  per-stage valid vector; bit 0 is the youngest
- stall_count  out  CNT_W  saturating count of stalled advances
- flush_count  out  CNT_W  saturating count of flushing advances

Behaviour:
- State:
  - Each stage k holds {valid, rd, we, is_load}.
  - All state updates occur only on clk edges where Reset=1 and advance=1. Otherwise state holds.
- Reset:
  - Reset=0 at a clk edge clears all valid bits and both counters.
  - Reset overrides advance.
  - An in-flight hazard is abandoned; no stall or flush survives reset.
- Outputs after reset: fwd_sel_a = fwd_sel_b = 0, stall = 0, flush = 0, id_ready = 1, stage_valid = 0.
- Forwarding (combinational from state and decode inputs):
  - fwd_sel_a = k+1 for the youngest k with valid[k] & we[k] & rd[k]==id_rs1 & id_rs1!=ZERO_REG & id_use_rs1.
  - Otherwise fwd_sel_a = 0.
  - fwd_sel_b is the same rule using id_rs2 and id_use_rs2.
  - The youngest matching stage has priority.
- Stall (combinational):
  - stall = id_valid & ~flush & (a match as above exists in some stage k < LOAD_LAT with is_load[k]).
  - The forwarding select is still driven during a stall but is not meaningful.
  - With LOAD_LAT=0, stall is constantly 0.
- Flush (combinational): flush = branch_taken & valid[DEPTH-1].
- Advance, normal (no flush, no stall):
  - Stage 0 takes {id_valid, id_rd, id_we, id_is_load}.
  - Stage k takes stage k-1.
- Advance with stall:
  - Stage 0 takes a bubble (valid=0); stages k>=1 shift.
  - stall_count increments.
- Advance with flush:
  - Stages 1..DEPTH-1 take valid=0; stage 0 takes a bubble. The decode instruction is discarded.
  - flush_count increments.
  - Flush has priority over stall; stall is forced to 0 while flush=1.
- Counters saturate at all-ones and do not wrap.
- branch_taken with valid[DEPTH-1]=0 is ignored: flush=0 and the advance is normal.
- DEPTH=1: stage 0 is also the oldest stage. A flush kills only the incoming instruction.

Test Plan:
- Reset: hold Reset=0 for 2 clk with advance=1 -> stage_valid=00, stall=0, flush=0, fwd_sel_a=0, both counters 0.
- Forward age, DEPTH=2:
  - Advance ADD rd=3 we=1, then present rs1=3 use_rs1=1 -> fwd_sel_a=1.
  - Advance an unrelated instruction -> fwd_sel_a=2.
  - Advance once more -> fwd_sel_a=0.
- Priority and zero register:
  - Stage 0 and stage 1 both rd=5 we=1, rs2=5 -> fwd_sel_b=1.
  - Stage 0 rd=31 we=1, rs1=31 -> fwd_sel_a=0.
- Load-use:
  - Stage 0 LDUR rd=7, decode rs1=7 -> stall=1, id_ready=0.
  - Advance -> stage_valid=10, stall=0, fwd_sel_a=2, stall_count=1.
- Branch flush over stall:
  - Stage 1 valid, stage 0 is a load to rd=7, decode rs1=7, branch_taken=1 -> flush=1, stall=0.
  - Advance -> stage_valid=00, flush_count=1, stall_count unchanged.
- Saturation: force 2^CNT_W+3 stalled advances -> stall_count = all-ones. Then Reset=0 for 1 clk -> both counters 0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: destination-tag pipeline for operand forwarding,
// load-use stalls and taken-branch flushes. State moves only on advance.
module pipe_hazard_unit #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             advance,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             branch_taken,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic             stall,
    output logic             id_ready,
    output logic             flush,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] we_q, we_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [REG_W-1:0] rd_q [DEPTH];
    logic [REG_W-1:0] rd_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [DEPTH-1:0] hit_a, hit_b;
    logic             ld_hazard;

    // Per-stage operand matches; the zero register never forwards.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            hit_a[k] = valid_q[k] & we_q[k] & (rd_q[k] == id_rs1) &
                       (id_rs1 != REG_W'(ZERO_REG)) & id_use_rs1;
            hit_b[k] = valid_q[k] & we_q[k] & (rd_q[k] == id_rs2) &
                       (id_rs2 != REG_W'(ZERO_REG)) & id_use_rs2;
        end
    end

    // Youngest matching stage wins: scan oldest to youngest, younger overwrites.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        for (int unsigned k = DEPTH; k > 0; k--) begin
            if (hit_a[k-1]) fwd_sel_a = SEL_W'(k);
            if (hit_b[k-1]) fwd_sel_b = SEL_W'(k);
        end
    end

    // Load-use hazard: a match against a load whose data is not ready yet.
    always_comb begin
        ld_hazard = 1'b0;
        for (int unsigned k = 0; k < LOAD_LAT; k++) begin
            if (ld_q[k] & (hit_a[k] | hit_b[k])) ld_hazard = 1'b1;
        end
    end

    // Control outputs; flush takes priority over stall.
    always_comb begin
        flush       = branch_taken & valid_q[DEPTH-1];
        stall       = id_valid & ~flush & ld_hazard;
        id_ready    = ~stall;
        stage_valid = valid_q;
        stall_count = stall_cnt_q;
        flush_count = flush_cnt_q;
    end

    // Next-state: shift tags, inject decode / bubble, bump saturating counters.
    always_comb begin
        valid_d     = valid_q;
        we_d        = we_q;
        ld_d        = ld_q;
        rd_d        = rd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (advance) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                we_d[k]    = we_q[k-1];
                ld_d[k]    = ld_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            valid_d[0] = id_valid;
            we_d[0]    = id_we;
            ld_d[0]    = id_is_load;
            rd_d[0]    = id_rd;
            if (flush) begin
                valid_d = '0;
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (stall) begin
                valid_d[0] = 1'b0;
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            valid_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Tag payload needs no reset; it is qualified by valid.
    always_ff @(posedge clk) begin
        we_q <= we_d;
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed testbench for pipe_hazard_unit (DEPTH=2, LOAD_LAT=1, narrow counters).
module tb_pipe_hazard_unit;

    localparam int unsigned TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                Reset;
    logic                advance;
    logic                id_valid;
    logic [4:0]          id_rs1, id_rs2, id_rd;
    logic                id_use_rs1, id_use_rs2, id_we, id_is_load;
    logic                branch_taken;
    logic [1:0]          fwd_sel_a, fwd_sel_b;
    logic                stall, id_ready, flush;
    logic [1:0]          stage_valid;
    logic [TB_CNT_W-1:0] stall_count, flush_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pipe_hazard_unit #(
        .REG_W   (5),
        .DEPTH   (2),
        .LOAD_LAT(1),
        .ZERO_REG(31),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .advance     (advance),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .branch_taken(branch_taken),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .stall       (stall),
        .id_ready    (id_ready),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_we = we; id_is_load = ld;
        #1;
    endtask

    task automatic adv();
        advance = 1'b1;
        @(posedge clk);
        #1;
        advance = 1'b0;
        #1;
    endtask

    initial begin
        Reset = 1'b0; advance = 1'b1; branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        advance = 1'b0;
        #1;
        check_eq("rst_valid", stage_valid, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_sel_a", fwd_sel_a, 0);
        check_eq("rst_sel_b", fwd_sel_b, 0);
        check_eq("rst_ready", id_ready, 1);
        check_eq("rst_scnt", stall_count, 0);
        check_eq("rst_fcnt", flush_count, 0);
        @(negedge clk);
        Reset = 1'b1;

        // Forwarding age
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        adv();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        check_eq("age_s0", fwd_sel_a, 1);
        check_eq("age_s0_stall", stall, 0);
        adv();
        check_eq("age_s1", fwd_sel_a, 2);
        adv();
        check_eq("age_gone", fwd_sel_a, 0);
        check_eq("age_valid", stage_valid, 3);

        // Priority and zero register
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        adv();
        adv();
        set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd31, 1'b1, 1'b0);
        check_eq("prio_b", fwd_sel_b, 1);
        id_use_rs2 = 1'b0; #1;
        check_eq("nouse_b", fwd_sel_b, 0);
        id_use_rs2 = 1'b1; #1;
        adv();
        set_id(1'b1, 5'd31, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        check_eq("zero_a", fwd_sel_a, 0);
        check_eq("old_b", fwd_sel_b, 2);

        // Load-use
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        adv();
        set_id(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        check_eq("lu_novalid", stall, 0);
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        check_eq("lu_stall", stall, 1);
        check_eq("lu_ready", id_ready, 0);
        check_eq("lu_sel", fwd_sel_a, 1);
        adv();
        check_eq("lu_bubble", stage_valid, 2);
        check_eq("lu_clear", stall, 0);
        check_eq("lu_fwd", fwd_sel_a, 2);
        check_eq("lu_scnt", stall_count, 1);
        adv();
        check_eq("lu_enter", stage_valid, 1);

        // Flush beats stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        adv();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        branch_taken = 1'b1; #1;
        check_eq("br_flush", flush, 1);
        check_eq("br_nostall", stall, 0);
        check_eq("br_ready", id_ready, 1);
        adv();
        check_eq("br_valid", stage_valid, 0);
        check_eq("br_fcnt", flush_count, 1);
        check_eq("br_scnt", stall_count, 1);
        check_eq("br_ignored", flush, 0);
        adv();
        check_eq("br_ign_valid", stage_valid, 1);
        check_eq("br_ign_fcnt", flush_count, 1);
        branch_taken = 1'b0;
        adv();

        // Saturation: self-dependent load alternates enter / stall
        Reset = 1'b0; adv(); Reset = 1'b1;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) adv();
        check_eq("sat_mid", stall_count, 10);
        for (int i = 0; i < 2 * ((1 << TB_CNT_W) + 3); i++) adv();
        check_eq("sat_full", stall_count, (1 << TB_CNT_W) - 1);
        check_eq("sat_fcnt", flush_count, 0);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b1;
        #1;
        check_eq("sat_rst_s", stall_count, 0);
        check_eq("sat_rst_f", flush_count, 0);
        check_eq("sat_rst_v", stage_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
